// File: rtl/cnn_pkg.sv
// Shared CNN front-end definitions: image geometry, UART frame header,
// loader error codes and FSM state encoding.
package cnn_pkg;

  localparam int IMG_SIZE = 28;
  localparam int IF_SZ    = IMG_SIZE * IMG_SIZE;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CSUM    = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_BUSY    = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PIXELS = 2'b01,
    ST_CSUM   = 2'b10
  } ldr_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pix_q_lut.sv
// Byte-to-Q-format pixel conversion, round(k * 2^FRAC_BITS / 255), as a
// 256-entry constant table with a registered, load-enabled output.
module pix_q_lut #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic [7:0]            i_byte,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] w_rom [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    assign w_rom[g] = DATA_WIDTH'(((g << FRAC_BITS) + 127) / 255);
  end

  // Output only moves on accepted pixels so it stays stable between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= w_rom[i_byte];
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Loads one 784-pixel image frame from a UART byte stream into the IFMAP,
// validating an 8-bit additive checksum and an inter-byte timeout.
//
//   state     | meaning
//   ST_IDLE   | waiting for header byte 0xA5, other bytes dropped
//   ST_PIXELS | writing pixel bytes to IFMAP, accumulating checksum
//   ST_CSUM   | waiting for the checksum byte
module uart_frame_loader
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 7,
  parameter int IMG_SIZE       = cnn_pkg::IMG_SIZE,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 rx_dv,
  input  logic [7:0]                           rx_byte,
  input  logic                                 pipe_busy,
  output logic                                 wr_en,
  output logic [$clog2(IMG_SIZE*IMG_SIZE)-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 frame_loaded,
  output logic                                 frame_error,
  output logic [1:0]                           err_code,
  output logic                                 loading,
  output logic [15:0]                          frames_ok,
  output logic [15:0]                          frames_bad
);

  localparam int              L_IF_SZ = IMG_SIZE * IMG_SIZE;
  localparam int              L_AW    = $clog2(L_IF_SZ);
  localparam int              L_TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [L_AW-1:0] L_LAST  = L_AW'(L_IF_SZ - 1);
  localparam logic [L_TW-1:0] L_TC    = L_TW'(TIMEOUT_CYCLES - 1);

  ldr_state_t      r_state;
  logic [L_AW-1:0] r_idx;
  logic [7:0]      r_csum;
  logic [L_TW-1:0] r_tmo;
  logic            r_wr_en;
  logic [L_AW-1:0] r_wr_addr;
  logic            r_loaded;
  logic            r_error;
  err_code_t       r_err;
  logic            r_loading;
  logic [15:0]     r_ok;
  logic [15:0]     r_bad;

  logic w_pix_en;
  logic w_tmo_hit;

  assign w_pix_en = rx_dv && (r_state == ST_PIXELS);

  // A byte arriving on the terminal-count cycle keeps the frame alive.
  assign w_tmo_hit = (r_state != ST_IDLE) && !rx_dv && (r_tmo == L_TC);

  pix_q_lut #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_pix_q_lut (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_pix_en),
    .i_byte (rx_byte),
    .o_q    (wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_csum    <= '0;
      r_tmo     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_loaded  <= 1'b0;
      r_error   <= 1'b0;
      r_err     <= ERR_NONE;
      r_loading <= 1'b0;
      r_ok      <= '0;
      r_bad     <= '0;
    end else begin
      r_wr_en  <= 1'b0;
      r_loaded <= 1'b0;
      r_error  <= 1'b0;

      if (w_tmo_hit) begin
        r_state   <= ST_IDLE;
        r_loading <= 1'b0;
        r_tmo     <= '0;
        r_error   <= 1'b1;
        r_err     <= ERR_TIMEOUT;
        r_bad     <= sat_inc16(r_bad);
      end else begin
        r_tmo <= (rx_dv || (r_state == ST_IDLE)) ? '0 : r_tmo + L_TW'(1);

        case (r_state)
          ST_IDLE: begin
            if (rx_dv && (rx_byte == HDR_BYTE)) begin
              if (pipe_busy) begin
                r_error <= 1'b1;
                r_err   <= ERR_BUSY;
                r_bad   <= sat_inc16(r_bad);
              end else begin
                r_state   <= ST_PIXELS;
                r_loading <= 1'b1;
                r_idx     <= '0;
                r_csum    <= '0;
              end
            end
          end

          ST_PIXELS: begin
            if (rx_dv) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_idx;
              r_csum    <= r_csum + rx_byte;
              if (r_idx == L_LAST) begin
                r_state <= ST_CSUM;
                r_idx   <= '0;
              end else begin
                r_idx <= r_idx + L_AW'(1);
              end
            end
          end

          ST_CSUM: begin
            if (rx_dv) begin
              r_state   <= ST_IDLE;
              r_loading <= 1'b0;
              if (rx_byte == r_csum) begin
                r_loaded <= 1'b1;
                r_ok     <= sat_inc16(r_ok);
              end else begin
                r_error <= 1'b1;
                r_err   <= ERR_CSUM;
                r_bad   <= sat_inc16(r_bad);
              end
            end
          end

          default: begin
            r_state   <= ST_IDLE;
            r_loading <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign frame_loaded = r_loaded;
  assign frame_error  = r_error;
  assign err_code     = r_err;
  assign loading      = r_loading;
  assign frames_ok    = r_ok;
  assign frames_bad   = r_bad;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: good, bad-checksum, busy, timeout,
// garbage/0xA5-payload and mid-frame reset frames.
module tb_uart_frame_loader;

  localparam int TMO   = 50;
  localparam int IF_SZ = 784;

  logic        clk;
  logic        reset;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        pipe_busy;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_loaded;
  logic        frame_error;
  logic [1:0]  err_code;
  logic        loading;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;

  int n_checks = 0;
  int n_fail   = 0;

  uart_frame_loader #(
    .DATA_WIDTH     (16),
    .FRAC_BITS      (7),
    .IMG_SIZE       (28),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_dv        (rx_dv),
    .rx_byte      (rx_byte),
    .pipe_busy    (pipe_busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_loaded (frame_loaded),
    .frame_error  (frame_error),
    .err_code     (err_code),
    .loading      (loading),
    .frames_ok    (frames_ok),
    .frames_bad   (frames_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_q(input logic [7:0] k);
    return 16'((int'(k) * 128 + 127) / 255);
  endfunction

  function automatic logic [7:0] pix_val(input int mode, input int i);
    case (mode)
      0:       return 8'h01;
      1:       return 8'(i % 256);
      default: return (i % 5 == 0) ? 8'hA5 : 8'((i * 3) % 256);
    endcase
  endfunction

  // Called at a negedge; returns at the next negedge with the byte consumed.
  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_wr_en"},   32'(wr_en), 0);
    check_val({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check_val({tag, "_wr_data"}, 32'(wr_data), 0);
    check_val({tag, "_loaded"},  32'(frame_loaded), 0);
    check_val({tag, "_error"},   32'(frame_error), 0);
    check_val({tag, "_err"},     32'(err_code), 0);
    check_val({tag, "_loading"}, 32'(loading), 0);
    check_val({tag, "_ok"},      32'(frames_ok), 0);
    check_val({tag, "_bad"},     32'(frames_bad), 0);
  endtask

  task automatic send_frame(input int mode, input int n_pix, input logic [7:0] cs_xor,
                            input int busy_at, input int gap_at);
    logic [7:0] p;
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(8'hA5);
    check_val("hdr_loading", 32'(loading), 1);
    check_val("hdr_no_wr", 32'(wr_en), 0);
    for (int i = 0; i < n_pix; i++) begin
      p = pix_val(mode, i);
      if (i == busy_at) pipe_busy = 1'b1;
      if (i == gap_at) repeat (TMO - 1) @(negedge clk);
      send_byte(p);
      cs = cs + p;
      check_val("pix_wr_en", 32'(wr_en), 1);
      check_val("pix_wr_addr", 32'(wr_addr), 32'(i));
      check_val("pix_wr_data", 32'(wr_data), 32'(exp_q(p)));
      if (i == gap_at) begin
        check_val("tc_rx_wins_err", 32'(frame_error), 0);
        check_val("tc_rx_wins_loading", 32'(loading), 1);
      end
      if (mode == 1 && i == 255) check_val("ramp_255_q", 32'(wr_data), 128);
      if (mode == 0 && i == 0)   check_val("one_q", 32'(wr_data), 1);
    end
    if (n_pix == IF_SZ) begin
      check_val("csum_loading", 32'(loading), 1);
      send_byte(cs ^ cs_xor);
      check_val("csum_loading_done", 32'(loading), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    reset     = 1'b1;
    rx_dv     = 1'b0;
    rx_byte   = 8'h00;
    pipe_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Good frame of all 0x01, checksum 784 mod 256 = 0x10
    send_frame(0, IF_SZ, 8'h00, -1, -1);
    check_val("good_loaded", 32'(frame_loaded), 1);
    check_val("good_no_err", 32'(frame_error), 0);
    check_val("good_ok", 32'(frames_ok), 1);
    check_val("good_bad", 32'(frames_bad), 0);
    @(negedge clk);
    check_val("good_pulse_1cyc", 32'(frame_loaded), 0);

    // Ramp frame with corrupted checksum
    send_frame(1, IF_SZ, 8'hFF, -1, -1);
    check_val("ramp_err", 32'(frame_error), 1);
    check_val("ramp_no_loaded", 32'(frame_loaded), 0);
    check_val("ramp_code", 32'(err_code), 1);
    check_val("ramp_bad", 32'(frames_bad), 1);
    check_val("ramp_ok", 32'(frames_ok), 1);
    @(negedge clk);

    // Header while the pipeline is busy
    pipe_busy = 1'b1;
    send_byte(8'hA5);
    check_val("busy_err", 32'(frame_error), 1);
    check_val("busy_code", 32'(err_code), 3);
    check_val("busy_no_wr", 32'(wr_en), 0);
    check_val("busy_loading", 32'(loading), 0);
    check_val("busy_bad", 32'(frames_bad), 2);
    pipe_busy = 1'b0;
    @(negedge clk);
    check_val("busy_pulse_1cyc", 32'(frame_error), 0);
    send_frame(0, IF_SZ, 8'h00, 100, -1);
    check_val("after_busy_loaded", 32'(frame_loaded), 1);
    check_val("after_busy_ok", 32'(frames_ok), 2);
    pipe_busy = 1'b0;
    @(negedge clk);

    // 500 pixels then silence
    send_frame(0, 500, 8'h00, -1, -1);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (frame_error) seen = 1'b1;
    end
    check_val("tmo_latency", 32'(cnt), TMO);
    check_val("tmo_code", 32'(err_code), 2);
    check_val("tmo_loading", 32'(loading), 0);
    check_val("tmo_bad", 32'(frames_bad), 3);
    @(negedge clk);
    check_val("tmo_pulse_1cyc", 32'(frame_error), 0);
    send_byte(8'h01);
    check_val("tmo_idle_no_wr", 32'(wr_en), 0);

    // Garbage before header, 0xA5 inside payload, byte on terminal count
    send_byte(8'h00);
    check_val("garb00_no_wr", 32'(wr_en), 0);
    check_val("garb00_loading", 32'(loading), 0);
    send_byte(8'hFF);
    check_val("garbFF_no_wr", 32'(wr_en), 0);
    check_val("garbFF_no_err", 32'(frame_error), 0);
    send_frame(2, IF_SZ, 8'h00, -1, 10);
    check_val("a5data_loaded", 32'(frame_loaded), 1);
    check_val("a5data_ok", 32'(frames_ok), 3);
    check_val("a5data_bad", 32'(frames_bad), 3);
    check_val("a5data_code_kept", 32'(err_code), 2);
    @(negedge clk);

    // Reset at pixel 300, with rx_dv coinciding with reset
    send_frame(0, 300, 8'h00, -1, -1);
    reset   = 1'b1;
    rx_dv   = 1'b1;
    rx_byte = 8'h01;
    @(negedge clk);
    check_val("midrst_no_err", 32'(frame_error), 0);
    @(negedge clk);
    reset = 1'b0;
    rx_dv = 1'b0;
    check_reset_vals("midrst");
    @(negedge clk);
    check_val("midrst_idle", 32'(loading), 0);
    send_frame(1, IF_SZ, 8'h00, -1, -1);
    check_val("post_rst_loaded", 32'(frame_loaded), 1);
    check_val("post_rst_ok", 32'(frames_ok), 1);
    check_val("post_rst_bad", 32'(frames_bad), 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
